// File: rtl/puf_pkg.sv
// Shared definitions for the PUF evaluation controller: register map,
// CTRL/STATUS bit positions, FSM states and the reset settle time.
package puf_pkg;

    localparam logic [2:0] REG_CTRL     = 3'd0;
    localparam logic [2:0] REG_CHAL     = 3'd1;
    localparam logic [2:0] REG_SETTLE   = 3'd2;
    localparam logic [2:0] REG_RESP     = 3'd3;
    localparam logic [2:0] REG_STATUS   = 3'd4;
    localparam logic [2:0] REG_UNSTABLE = 3'd5;

    localparam int CTRL_START_BIT = 0;
    localparam int CTRL_CLEAR_BIT = 1;
    localparam int STAT_DONE_BIT  = 0;
    localparam int STAT_BUSY_BIT  = 1;

    localparam int DEFAULT_SETTLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RESET,
        ST_SETTLE,
        ST_SAMPLE,
        ST_VOTE
    } state_t;

endpackage

// File: rtl/puf_vote_counter.sv
// One PUF channel: 2-flop synchronizer, ones counter and majority vote.
// Build with PUF_STABILITY_EN to also flag channels that disagree with their first sample.
module puf_vote_counter #(
    parameter int REPEATS = 7
) (
    input  logic clk,
    input  logic reset_n,
    input  logic puf_in,
    input  logic clear,
    input  logic sample,
    input  logic vote,
    output logic resp,
    output logic unstable
);
    localparam int CW = $clog2(REPEATS + 1);
    localparam logic [CW:0] REP = (CW + 1)'(REPEATS);

    logic          sync1_q, sync1_d;
    logic          sync2_q, sync2_d;
    logic [CW-1:0] ones_q, ones_d;
    logic          resp_q, resp_d;

    always_comb begin
        sync1_d = puf_in;
        sync2_d = sync1_q;
        ones_d  = ones_q;
        resp_d  = resp_q;
        if (clear) begin
            ones_d = '0;
        end else if (sample) begin
            ones_d = ones_q + CW'(sync2_q);
        end
        // ones*2 > REPEATS: strict majority, a tie votes 0
        if (vote) begin
            resp_d = ({ones_q, 1'b0} > REP);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            ones_q  <= '0;
            resp_q  <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            ones_q  <= ones_d;
            resp_q  <= resp_d;
        end
    end

    assign resp = resp_q;

`ifdef PUF_STABILITY_EN
    logic seen_q, seen_d;
    logic first_q, first_d;
    logic diff_q, diff_d;
    logic unst_q, unst_d;

    always_comb begin
        seen_d  = seen_q;
        first_d = first_q;
        diff_d  = diff_q;
        unst_d  = unst_q;
        if (clear) begin
            seen_d = 1'b0;
            diff_d = 1'b0;
        end else if (sample) begin
            if (!seen_q) begin
                seen_d  = 1'b1;
                first_d = sync2_q;
            end else if (sync2_q != first_q) begin
                diff_d = 1'b1;
            end
        end
        if (vote) begin
            unst_d = diff_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            seen_q  <= 1'b0;
            first_q <= 1'b0;
            diff_q  <= 1'b0;
            unst_q  <= 1'b0;
        end else begin
            seen_q  <= seen_d;
            first_q <= first_d;
            diff_q  <= diff_d;
            unst_q  <= unst_d;
        end
    end

    assign unstable = unst_q;
`else
    assign unstable = 1'b0;
`endif

endmodule

// File: rtl/puf_eval_ctrl.sv
// Multi-channel PUF evaluation controller with a one-cycle-ack register slave.
// Optional macro PUF_STABILITY_EN enables the per-channel UNSTABLE register.
module puf_eval_ctrl
    import puf_pkg::*;
#(
    parameter int CHAL_BITS      = 32,
    parameter int CHANNELS       = 8,
    parameter int REPEATS        = 7,
    parameter int SETTLE_W       = 16,
    parameter int PUF_RST_CYCLES = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 valid,
    input  logic [2:0]           addr,
    input  logic [3:0]           wstrb,
    input  logic [31:0]          wdata,
    output logic                 ready,
    output logic [31:0]          rdata,
    output logic [CHAL_BITS-1:0] puf_challenge,
    output logic                 puf_reset,
    input  logic [CHANNELS-1:0]  puf_response,
    output logic                 irq
);
    localparam logic [SETTLE_W-1:0] RST_LAST  = SETTLE_W'(PUF_RST_CYCLES - 1);
    localparam logic [7:0]          EVAL_LAST = 8'(REPEATS - 1);

    state_t                state_q, state_d;
    logic [SETTLE_W-1:0]   cnt_q, cnt_d;
    logic [7:0]            eval_idx_q, eval_idx_d;
    logic                  done_q, done_d;
    logic [CHAL_BITS-1:0]  chal_q, chal_d;
    logic [SETTLE_W-1:0]   settle_q, settle_d;
    logic                  ready_q, ready_d;
    logic [31:0]           rdata_q, rdata_d;
    logic                  irq_q, irq_d;

    logic [CHANNELS-1:0]   resp_w;
    logic [CHANNELS-1:0]   unst_w;
    logic [31:0]           rd_word;
    logic [SETTLE_W-1:0]   settle_last;
    logic                  busy, access, wr, ctrl_wr, start_req, clr_req, launch;

    assign busy      = (state_q != ST_IDLE);
    assign access    = valid && !ready_q;
    assign wr        = access && (wstrb != 4'b0000);
    assign ctrl_wr   = wr && (addr == REG_CTRL) && wstrb[0];
    assign start_req = ctrl_wr && wdata[CTRL_START_BIT];
    assign clr_req   = ctrl_wr && wdata[CTRL_CLEAR_BIT];
    // clear_done in the same write re-arms a finished run before the start is judged
    assign launch    = start_req && !busy && (!done_q || clr_req);
    assign settle_last = (settle_q == '0) ? '0 : settle_q - SETTLE_W'(1);

    always_comb begin
        rd_word = '0;
        case (addr)
            REG_CTRL: begin
                rd_word[STAT_BUSY_BIT] = busy;
                rd_word[STAT_DONE_BIT] = done_q;
            end
            REG_CHAL:     rd_word = 32'(chal_q);
            REG_SETTLE:   rd_word = 32'(settle_q);
            REG_RESP:     rd_word = 32'(resp_w);
            REG_STATUS: begin
                rd_word[15:8]          = eval_idx_q;
                rd_word[STAT_BUSY_BIT] = busy;
                rd_word[STAT_DONE_BIT] = done_q;
            end
            REG_UNSTABLE: rd_word = 32'(unst_w);
            default:      rd_word = '0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        eval_idx_d = eval_idx_q;
        done_d     = done_q;
        chal_d     = chal_q;
        settle_d   = settle_q;
        ready_d    = access;
        rdata_d    = access ? rd_word : rdata_q;
        irq_d      = 1'b0;
        puf_reset  = 1'b1;

        if (clr_req) begin
            done_d = 1'b0;
        end
        // configuration is frozen while a run is in flight
        if (wr && !busy && (addr == REG_CHAL)) begin
            for (int i = 0; i < CHAL_BITS; i++) begin
                if (wstrb[i / 8]) chal_d[i] = wdata[i];
            end
        end
        if (wr && !busy && (addr == REG_SETTLE)) begin
            for (int i = 0; i < SETTLE_W; i++) begin
                if (wstrb[i / 8]) settle_d[i] = wdata[i];
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    state_d    = ST_RESET;
                    cnt_d      = '0;
                    eval_idx_d = '0;
                    done_d     = 1'b0;
                end
            end
            ST_RESET: begin
                if (cnt_q == RST_LAST) begin
                    cnt_d   = '0;
                    state_d = ST_SETTLE;
                end else begin
                    cnt_d = cnt_q + SETTLE_W'(1);
                end
            end
            ST_SETTLE: begin
                puf_reset = 1'b0;
                if (cnt_q == settle_last) begin
                    cnt_d   = '0;
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + SETTLE_W'(1);
                end
            end
            ST_SAMPLE: begin
                puf_reset  = 1'b0;
                cnt_d      = '0;
                eval_idx_d = eval_idx_q + 8'd1;
                state_d    = (eval_idx_q == EVAL_LAST) ? ST_VOTE : ST_RESET;
            end
            ST_VOTE: begin
                done_d  = 1'b1;
                irq_d   = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            eval_idx_q <= '0;
            done_q     <= 1'b0;
            chal_q     <= '0;
            settle_q   <= SETTLE_W'(DEFAULT_SETTLE);
            ready_q    <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            eval_idx_q <= eval_idx_d;
            done_q     <= done_d;
            chal_q     <= chal_d;
            settle_q   <= settle_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        puf_vote_counter #(.REPEATS(REPEATS)) u_cnt (
            .clk      (clk),
            .reset_n  (reset_n),
            .puf_in   (puf_response[g]),
            .clear    (launch),
            .sample   (state_q == ST_SAMPLE),
            .vote     (state_q == ST_VOTE),
            .resp     (resp_w[g]),
            .unstable (unst_w[g])
        );
    end

    assign ready         = ready_q;
    assign rdata         = rdata_q;
    assign irq           = irq_q;
    assign puf_challenge = chal_q;

endmodule

// File: tb/tb_puf_eval_ctrl.sv
// Self-checking bench for puf_eval_ctrl: register table, back-to-back handshake,
// voting runs with stub PUF cells, bus lock, settle=0 and asynchronous abort.
module tb_puf_eval_ctrl;

`ifdef PUF_STABILITY_EN
    localparam logic [31:0] STAB = 32'd1;
`else
    localparam logic [31:0] STAB = 32'd0;
`endif

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        valid = 1'b0;
    logic [2:0]  addr = 3'd0;
    logic [3:0]  wstrb = 4'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready;
    logic [31:0] rdata;
    logic [31:0] puf_challenge;
    logic        puf_reset;
    logic [7:0]  puf_response;
    logic        irq;

    puf_eval_ctrl dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .valid         (valid),
        .addr          (addr),
        .wstrb         (wstrb),
        .wdata         (wdata),
        .ready         (ready),
        .rdata         (rdata),
        .puf_challenge (puf_challenge),
        .puf_reset     (puf_reset),
        .puf_response  (puf_response),
        .irq           (irq)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    int irq_cnt = 0;
    int nfall = 0;
    int base = 0;
    int last_acc = 0;
    int n_chk = 0;
    int n_pass = 0;
    logic [7:0]  pat [7];
    logic [31:0] sb [$];

    always @(posedge clk) cyc = cyc + 1;
    always @(posedge clk) if (irq === 1'b1) irq_cnt = irq_cnt + 1;
    always @(negedge puf_reset) nfall = nfall + 1;

    // stub cells: pattern entry k is presented from the k-th reset release of the run
    always_comb begin : stub
        int k;
        k = nfall - base - 1;
        if (k < 0) k = 0;
        if (k > 6) k = 6;
        puf_response = pat[k];
    end

    typedef struct {
        string       nm;
        logic [2:0]  a;
        logic [3:0]  s;
        logic [31:0] d;
        logic [31:0] e;
        bit          rd;
    } vec_t;
    vec_t tbl [17];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    task automatic access(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d,
                          output logic [31:0] r);
        int n;
        n = 0;
        valid = 1'b1; addr = a; wstrb = s; wdata = d;
        do begin
            @(posedge clk); #1; n++;
        end while (ready !== 1'b1 && n < 10);
        if (ready !== 1'b1) chk("ready_timeout", {31'b0, ready}, 32'd1);
        r = rdata;
        last_acc = cyc;
        valid = 1'b0; wstrb = 4'd0;
        @(posedge clk); #1;
        chk("ready_one_cycle", {31'b0, ready}, 32'd0);
    endtask

    task automatic wr(input logic [2:0] a, input logic [3:0] s, input logic [31:0] d);
        logic [31:0] r;
        access(a, s, d, r);
    endtask

    task automatic rd_chk(input string nm, input logic [2:0] a, input logic [31:0] e);
        logic [31:0] r;
        sb.push_back(e);
        access(a, 4'd0, 32'd0, r);
        chk(nm, r, sb.pop_front());
    endtask

    task automatic wait_irq(input string nm, input int c0, input int lat);
        int g;
        g = 0;
        while (irq !== 1'b1 && g < 3000) begin
            @(posedge clk); #1; g++;
        end
        chk(nm, 32'(cyc - c0), 32'(lat));
        @(posedge clk); #1;
        chk({nm, "_irq_one_cycle"}, {31'b0, irq}, 32'd0);
    endtask

    task automatic set_pat(input logic [7:0] p0, input logic [7:0] odd);
        for (int i = 0; i < 7; i++) pat[i] = (i % 2 == 0) ? p0 : odd;
        base = nfall;
    endtask

    initial begin
        int c0;
        int g;
        tbl[0]  = '{"rst_ctrl",    3'd0, 4'h0, 32'h0,        32'h0,        1'b1};
        tbl[1]  = '{"rst_settle",  3'd2, 4'h0, 32'h0,        32'h10,       1'b1};
        tbl[2]  = '{"rst_resp",    3'd3, 4'h0, 32'h0,        32'h0,        1'b1};
        tbl[3]  = '{"rst_status",  3'd4, 4'h0, 32'h0,        32'h0,        1'b1};
        tbl[4]  = '{"rst_unst",    3'd5, 4'h0, 32'h0,        32'h0,        1'b1};
        tbl[5]  = '{"wr_chal",     3'd1, 4'hF, 32'hDEADBEEF, 32'h0,        1'b0};
        tbl[6]  = '{"rd_chal",     3'd1, 4'h0, 32'h0,        32'hDEADBEEF, 1'b1};
        tbl[7]  = '{"wr_chal_b0",  3'd1, 4'h1, 32'h00000012, 32'h0,        1'b0};
        tbl[8]  = '{"rd_chal_b0",  3'd1, 4'h0, 32'h0,        32'hDEADBE12, 1'b1};
        tbl[9]  = '{"wr_idx6",     3'd6, 4'hF, 32'hFFFFFFFF, 32'h0,        1'b0};
        tbl[10] = '{"rd_idx6",     3'd6, 4'h0, 32'h0,        32'h0,        1'b1};
        tbl[11] = '{"wr_resp_ro",  3'd3, 4'hF, 32'h00000055, 32'h0,        1'b0};
        tbl[12] = '{"rd_resp_ro",  3'd3, 4'h0, 32'h0,        32'h0,        1'b1};
        tbl[13] = '{"wr_settle_b1",3'd2, 4'h2, 32'h00000300, 32'h0,        1'b0};
        tbl[14] = '{"rd_settle_b1",3'd2, 4'h0, 32'h0,        32'h310,      1'b1};
        tbl[15] = '{"wr_settle",   3'd2, 4'hF, 32'h00000010, 32'h0,        1'b0};
        tbl[16] = '{"rd_idx7",     3'd7, 4'h0, 32'h0,        32'h0,        1'b1};
        set_pat(8'h00, 8'h00);

        // asynchronous reset, checked before any clock edge
        #2 reset_n = 1'b0;
        #1;
        chk("rst_ready", {31'b0, ready}, 32'd0);
        chk("rst_rdata", rdata, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        chk("rst_puf_reset", {31'b0, puf_reset}, 32'd1);
        chk("rst_challenge", puf_challenge, 32'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 17; i++) begin
            if (tbl[i].rd) rd_chk(tbl[i].nm, tbl[i].a, tbl[i].e);
            else wr(tbl[i].a, tbl[i].s, tbl[i].d);
        end
        chk("challenge_pins", puf_challenge, 32'hDEADBE12);

        // valid held high: ack every second cycle
        valid = 1'b1; addr = 3'd2; wstrb = 4'd0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            chk($sformatf("b2b_ack_%0d", i), {31'b0, ready}, (i % 2 == 0) ? 32'd1 : 32'd0);
        end
        valid = 1'b0;
        @(posedge clk); #1;

        // run A: constant 0xA5, settle 16
        set_pat(8'hA5, 8'hA5);
        wr(3'd0, 4'hF, 32'h1);
        c0 = last_acc;
        wait_irq("lat_a5", c0, 148);
        chk("irq_cnt_a", 32'(irq_cnt), 32'd1);
        rd_chk("resp_a5", 3'd3, 32'h000000A5);
        rd_chk("ctrl_done_a", 3'd0, 32'h1);
        rd_chk("status_a", 3'd4, 32'h00000701);
        rd_chk("unst_a", 3'd5, 32'h0);

        // start with done set and no clear_done is ignored
        wr(3'd0, 4'hF, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        chk("ignored_start_puf_reset", {31'b0, puf_reset}, 32'd1);
        rd_chk("ignored_start_status", 3'd4, 32'h00000701);

        // run C: channel 0 votes 4 of 7 ones
        set_pat(8'hA5, 8'hA4);
        wr(3'd0, 4'hF, 32'h3);
        c0 = last_acc;
        wait_irq("lat_c", c0, 148);
        rd_chk("resp_4of7", 3'd3, 32'h000000A5);
        rd_chk("unst_c", 3'd5, STAB);

        // run D: channel 0 votes 3 of 7 ones, bus locked while busy
        set_pat(8'hA4, 8'hA5);
        wr(3'd0, 4'hF, 32'h3);
        c0 = last_acc;
        wr(3'd1, 4'hF, 32'h00000001);
        wr(3'd0, 4'hF, 32'h1);
        wr(3'd2, 4'hF, 32'h5);
        rd_chk("busy_resp_prev", 3'd3, 32'h000000A5);
        rd_chk("busy_ctrl", 3'd0, 32'h2);
        chk("busy_chal_pins", puf_challenge, 32'hDEADBE12);
        wait_irq("lat_d", c0, 148);
        rd_chk("resp_3of7", 3'd3, 32'h000000A4);
        rd_chk("unst_d", 3'd5, STAB);
        rd_chk("chal_locked", 3'd1, 32'hDEADBE12);
        rd_chk("settle_locked", 3'd2, 32'h10);
        repeat (200) @(posedge clk);
        #1;
        chk("no_second_run", 32'(irq_cnt), 32'd3);
        rd_chk("ctrl_idle_d", 3'd0, 32'h1);

        // run E: settle 0 acts as 1
        wr(3'd2, 4'hF, 32'h0);
        rd_chk("settle_zero", 3'd2, 32'h0);
        set_pat(8'hFF, 8'hFF);
        wr(3'd0, 4'hF, 32'h3);
        c0 = last_acc;
        wait_irq("lat_settle0", c0, 43);
        rd_chk("resp_ff", 3'd3, 32'h000000FF);
        chk("irq_cnt_e", 32'(irq_cnt), 32'd4);

        // run F: asynchronous abort mid-SETTLE
        wr(3'd2, 4'hF, 32'h10);
        wr(3'd0, 4'hF, 32'h3);
        g = 0;
        while (puf_reset !== 1'b0 && g < 50) begin
            @(posedge clk); #1; g++;
        end
        chk("reached_settle", {31'b0, puf_reset}, 32'd0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b0;
        #1;
        chk("abort_puf_reset", {31'b0, puf_reset}, 32'd1);
        chk("abort_challenge", puf_challenge, 32'd0);
        chk("abort_irq", {31'b0, irq}, 32'd0);
        chk("abort_rdata", rdata, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        rd_chk("abort_ctrl", 3'd0, 32'h0);
        rd_chk("abort_resp", 3'd3, 32'h0);
        rd_chk("abort_status", 3'd4, 32'h0);
        rd_chk("abort_settle", 3'd2, 32'h10);
        repeat (200) @(posedge clk);
        #1;
        chk("abort_no_irq", 32'(irq_cnt), 32'd4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got cycle %0d expected finish", cyc);
        $fatal(1);
    end

endmodule
